// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// the overflow display pattern, and the largest value the digits can show.
// No logic of its own; constants and a constant function only.
package bin_to_bcd_converter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Digit pattern shown on every position when the operand cannot be displayed
   localparam logic [3:0] OVF_DIGIT = 4'hE;

   // Largest value representable with n decimal digits (10**n - 1)
   function automatic logic [31:0] max_val(input int unsigned n);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_converter_digit_adj.sv
// Purpose: double-dabble correction for one BCD digit (add 3 when digit >= 5).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module bcd_digit_adj (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   // Digit is at most 9 here, so the 4-bit add never carries out
   assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Purpose: sequential binary-to-BCD converter (shift-add-3) for the 4-digit display.
// Latency: done pulses BIN_WIDTH+1 cycles after the accepting start edge.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module bin_to_bcd_converter
   import bin_to_bcd_converter_pkg::*;
#(
   parameter int BIN_WIDTH  = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BIN_WIDTH-1:0]    bin_value,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [4*NUM_DIGITS-1:0] digit_data
);

   localparam int              BCD_W    = 4 * NUM_DIGITS;
   localparam int              CNT_W    = $clog2(BIN_WIDTH + 1);
   localparam logic [31:0]     MAX_VAL  = max_val(NUM_DIGITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

   state_t               state_q, state_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [BCD_W-1:0]     bcd_adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_pend_q, ovf_pend_d;
   logic [BCD_W-1:0]     digit_data_q, digit_data_d;
   logic                 overflow_q, overflow_d;
   logic                 done_q, done_d;

   // One correction slice per BCD digit of the accumulator
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_q[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

   // Next-state: accept in IDLE, run exactly BIN_WIDTH shifts, one publish cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath: load operand, shift-add-3, and publish the result in one step
   always_comb begin
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      ovf_pend_d   = ovf_pend_q;
      digit_data_d = digit_data_q;
      overflow_d   = overflow_q;
      done_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_d      = bin_value;
               bcd_d      = '0;
               cnt_d      = '0;
               // Overflow is decided here; top bits lost in the shift don't matter
               ovf_pend_d = (32'(bin_value) > MAX_VAL);
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
         end
         ST_DONE: begin
            // Whole word updates at once so the display never sees a partial value
            digit_data_d = ovf_pend_q ? {NUM_DIGITS{OVF_DIGIT}} : bcd_q;
            overflow_d   = ovf_pend_q;
            done_d       = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs: busy spans SHIFT and DONE; the rest come straight from flops
   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = done_q;
      overflow   = overflow_q;
      digit_data = digit_data_q;
   end

   // State and working registers; reset abandons any conversion in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         ovf_pend_q   <= 1'b0;
         digit_data_q <= '0;
         overflow_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         ovf_pend_q   <= ovf_pend_d;
         digit_data_q <= digit_data_d;
         overflow_q   <= overflow_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter: directed corner cases plus random operands,
// expected results queued at issue time and checked by an independent monitor on done.
module tb_bin_to_bcd_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [13:0] bin_value;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] digit_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [16:0] exp_q[$];
   bit          done_prev = 1'b0;

   bin_to_bcd_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bin_value  (bin_value),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .digit_data (digit_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Decimal reference: {overflow, packed digits} from plain division
   function automatic logic [16:0] ref_bcd(input int v);
      logic [15:0] d;
      int          p;
      if (v > 9999) return {1'b1, 16'hEEEE};
      d = '0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         d[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return {1'b0, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            chk("done_single_cycle", 32'(done_prev), 32'd0);
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done with empty queue, digit_data=%0h", digit_data);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("digit_data", 32'(digit_data), 32'(e[15:0]));
               chk("overflow", 32'(overflow), 32'(e[16]));
            end
         end
         done_prev = done;
      end else begin
         done_prev = 1'b0;
      end
   end

   // One conversion; optionally pulse a stray start dist_at cycles in
   task automatic convert(input int v, input int dist_at, input int dist_v);
      int nb;
      bit seen;
      start     = 1'b1;
      bin_value = 14'(v);
      exp_q.push_back(ref_bcd(v));
      tick();
      start = 1'b0;
      nb    = 0;
      seen  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) nb++;
            if (i == dist_at) begin
               start     = 1'b1;
               bin_value = 14'(dist_v);
            end else if (i == dist_at + 1) begin
               start = 1'b0;
            end
            tick();
         end
      end
      chk("busy_cycles", 32'(nb), 32'd15);
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_done(output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) begin
            c  = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Global bound in case the DUT stops responding
   initial begin
      #1500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int corners[13];
      int vals[3];
      int dc[3];
      bit ok;

      corners = '{0, 9999, 10000, 16383, 1, 4, 5, 9, 10, 99, 100, 999, 1000};
      vals    = '{5, 42, 870};

      reset     = 1'b1;
      start     = 1'b0;
      bin_value = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("reset_digit_data", 32'(digit_data), 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);

      convert(1234, -1, 0);
      foreach (corners[i]) convert(corners[i], -1, 0);

      // start held high: back-to-back conversions every BIN_WIDTH+2 cycles
      start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         bin_value = 14'(vals[j]);
         exp_q.push_back(ref_bcd(vals[j]));
         if (j > 0) begin
            wait_done(dc[j-1], ok);
            chk("b2b_done_seen", 32'(ok), 32'd1);
         end
         tick();
      end
      start = 1'b0;
      wait_done(dc[2], ok);
      chk("b2b_done_seen", 32'(ok), 32'd1);
      chk("b2b_gap_1", 32'(dc[1] - dc[0]), 32'd16);
      chk("b2b_gap_2", 32'(dc[2] - dc[1]), 32'd16);
      repeat (3) tick();

      // Stray start during conversion must be ignored
      convert(4321, 4, 999);
      repeat (20) tick();
      chk("ignored_start_queue", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a conversion
      convert(777, -1, 0);
      start     = 1'b1;
      bin_value = 14'd1234;
      tick();
      start = 1'b0;
      repeat (6) tick();
      reset = 1'b1;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_digit_data", 32'(digit_data), 32'h0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_overflow", 32'(overflow), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      convert(56, -1, 0);

      // Random operands over the full input range
      for (int n = 0; n < 2500; n++) begin
         convert(int'($urandom_range(0, 16383)), -1, 0);
      end

      repeat (5) tick();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
